case_conv_sched: RTL and testbench

CASE_CONV_SCHED -- requirements
Module: case_conv_sched

---
 rtl/case_conv_pkg.sv | 24 ++
 rtl/case_conv_core.sv | 35 +++
 rtl/case_conv_sched.sv | 160 ++++++++++++++++
 tb/tb_case_conv_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/case_conv_pkg.sv
// case_conv_pkg
//   Shared definitions for the case-converting two-requester scheduler:
//   mode encodings, arbiter state encoding and ASCII letter bounds.
package case_conv_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_UPPER = 2'b01,
      MODE_LOWER = 2'b10,
      MODE_SWAP  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } arb_state_t;

   localparam logic [7:0] UPPER_LO = 8'h41;
   localparam logic [7:0] UPPER_HI = 8'h5A;
   localparam logic [7:0] LOWER_LO = 8'h61;
   localparam logic [7:0] LOWER_HI = 8'h7A;

endpackage

// File: rtl/case_conv_core.sv
// case_conv_core
//   Purely combinational ASCII case converter. Only bytes inside the two
//   letter ranges are ever changed, and only bit 5 is flipped.
//   Ports:
//     i_byte  [7:0]  input byte
//     i_mode  [1:0]  pass / upper / lower / swap
//     o_byte  [7:0]  converted byte
module case_conv_core
   import case_conv_pkg::*;
(
   input  logic [7:0] i_byte,
   input  logic [1:0] i_mode,
   output logic [7:0] o_byte
);

   logic w_is_upper;
   logic w_is_lower;
   logic w_flip;

   assign w_is_upper = (i_byte >= UPPER_LO) && (i_byte <= UPPER_HI);
   assign w_is_lower = (i_byte >= LOWER_LO) && (i_byte <= LOWER_HI);

   always_comb begin
      w_flip = 1'b0;
      case (i_mode)
         MODE_UPPER: w_flip = w_is_lower;
         MODE_LOWER: w_flip = w_is_upper;
         MODE_SWAP:  w_flip = w_is_upper || w_is_lower;
         default:    w_flip = 1'b0;
      endcase
   end

   assign o_byte = i_byte ^ {2'b00, w_flip, 5'b00000};

endmodule

// File: rtl/case_conv_sched.sv
// case_conv_sched
//   Two requesters share one case converter and one output register.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid never waits on ready, and m_data/m_id hold while
//   m_valid is high and m_ready is low.
//   Arbitration is burst-limited round robin: the owner keeps the grant for
//   up to BURST consecutive bytes while the other side waits, and hands over
//   in the same cycle it stops (no idle cycle on a switch).
//   Ports:
//     clk, rst                      clock, async active-high reset
//     s0_valid/s0_data/s0_mode      requester 0 byte, mode
//     s0_ready                      requester 0 accepted
//     s1_*                          same for requester 1
//     m_valid/m_data/m_id/m_ready   converted byte output stream
//     busy                          any activity (held byte or pending input)
//     o_dbg_state [1:0]             arbiter state for observation
module case_conv_sched
   import case_conv_pkg::*;
#(
   parameter int BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s0_valid,
   input  logic [7:0] s0_data,
   input  logic [1:0] s0_mode,
   output logic       s0_ready,
   input  logic       s1_valid,
   input  logic [7:0] s1_data,
   input  logic [1:0] s1_mode,
   output logic       s1_ready,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_id,
   input  logic       m_ready,
   output logic       busy,
   output logic [1:0] o_dbg_state
);

   localparam logic [3:0] BURST_C = 4'(BURST);

   arb_state_t r_state;
   logic [3:0] r_cnt;
   logic       r_last_id;
   logic       r_m_valid;
   logic [7:0] r_m_data;
   logic       r_m_id;

   logic       w_load_ok;
   logic       w_cnt_full;
   logic       w_gnt_vld;
   logic       w_gnt_id;
   logic       w_accept;
   arb_state_t w_own;
   logic [7:0] w_sel_data;
   logic [1:0] w_sel_mode;
   logic [7:0] w_conv;

   assign w_load_ok  = !r_m_valid || m_ready;
   assign w_cnt_full = (r_cnt >= BURST_C);

   // Grant is a function of current state and valids only, so a change of
   // owner is decided and served in the same cycle.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
      case (r_state)
         ST_OWN0: begin
            if (s0_valid && (!w_cnt_full || !s1_valid)) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b0;
            end else if (s1_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b1;
            end
         end
         ST_OWN1: begin
            if (s1_valid && (!w_cnt_full || !s0_valid)) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b1;
            end else if (s0_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b0;
            end
         end
         default: begin
            if (s0_valid && s1_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = ~r_last_id;
            end else if (s0_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b0;
            end else if (s1_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = 1'b1;
            end
         end
      endcase
   end

   // The granted requester is always valid, so ready doubles as the
   // acceptance strobe.
   assign w_accept = w_gnt_vld && w_load_ok && !rst;
   assign s0_ready = w_accept && !w_gnt_id;
   assign s1_ready = w_accept &&  w_gnt_id;

   assign w_own      = w_gnt_id ? ST_OWN1 : ST_OWN0;
   assign w_sel_data = w_gnt_id ? s1_data : s0_data;
   assign w_sel_mode = w_gnt_id ? s1_mode : s0_mode;

   case_conv_core u_core (
      .i_byte (w_sel_data),
      .i_mode (w_sel_mode),
      .o_byte (w_conv)
   );

   // Arbiter. cnt counts bytes served in the current ownership; the byte
   // that opens an ownership is its first, so a switch reloads cnt with 1.
   // With load_ok low the arbiter is frozen, except that losing all valids
   // always returns it to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_last_id <= 1'b1;
      end else if (!s0_valid && !s1_valid) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else if (w_accept) begin
         r_last_id <= w_gnt_id;
         if (r_state == w_own) begin
            r_cnt <= w_cnt_full ? r_cnt : r_cnt + 4'd1;
         end else begin
            r_state <= w_own;
            r_cnt   <= 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= 8'h00;
         r_m_id    <= 1'b0;
      end else if (w_load_ok) begin
         r_m_valid <= w_accept;
         if (w_accept) begin
            r_m_data <= w_conv;
            r_m_id   <= w_gnt_id;
         end
      end
   end

   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign m_id        = r_m_id;
   assign busy        = r_m_valid || s0_valid || s1_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_case_conv_sched.sv
// tb_case_conv_sched
//   Directed bench for case_conv_sched with hand-computed expectations.
//   Inputs change on the falling edge; outputs are sampled 1 ns after an edge.
module tb_case_conv_sched;

   logic       clk;
   logic       rst;
   logic       s0_valid;
   logic [7:0] s0_data;
   logic [1:0] s0_mode;
   logic       s0_ready;
   logic       s1_valid;
   logic [7:0] s1_data;
   logic [1:0] s1_mode;
   logic       s1_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_id;
   logic       m_ready;
   logic       busy;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;

   case_conv_sched #(.BURST(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .s0_valid    (s0_valid),
      .s0_data     (s0_data),
      .s0_mode     (s0_mode),
      .s0_ready    (s0_ready),
      .s1_valid    (s1_valid),
      .s1_data     (s1_data),
      .s1_mode     (s1_mode),
      .s1_ready    (s1_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_id        (m_id),
      .m_ready     (m_ready),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_gap();
      @(negedge clk);
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      m_ready  = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
      checks++; if (m_id !== 1'b0) begin errors++; $display("FAIL reset_m_id got=%0b exp=0", m_id); end
      checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {s0_ready, s1_ready}); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", busy); end
      @(negedge clk);
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      rst      = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
   endtask

   // 'a' in upper mode on s0: 0x41 from id 0 one cycle later.
   task automatic test_single();
      @(negedge clk);
      s0_valid = 1'b1; s0_data = 8'h61; s0_mode = 2'b01; m_ready = 1'b1;
      #1;
      checks++; if ({s0_ready, s1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {s0_ready, s1_ready}); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%0b exp=0", m_valid); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", m_valid); end
      checks++; if (m_data !== 8'h41) begin errors++; $display("FAIL single_data got=%h exp=41", m_data); end
      checks++; if (m_id !== 1'b0) begin errors++; $display("FAIL single_id got=%0b exp=0", m_id); end
      @(negedge clk);
      s0_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", m_valid); end
   endtask

   // Back-to-back bytes on s0 across every mode and the letter-range edges.
   task automatic test_modes();
      logic [7:0] vin  [12];
      logic [1:0] vmode[12];
      logic [7:0] vexp [12];
      vin  = '{8'h61, 8'h41, 8'h41, 8'h7A, 8'h40, 8'h7B, 8'hE1, 8'h5A, 8'h60, 8'h5B, 8'h61, 8'h5A};
      vmode= '{2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
      vexp = '{8'h41, 8'h61, 8'h41, 8'h7A, 8'h40, 8'h7B, 8'hE1, 8'h7A, 8'h60, 8'h5B, 8'h61, 8'h7A};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         s0_valid = 1'b1; s0_data = vin[i]; s0_mode = vmode[i];
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b1 || m_data !== vexp[i]) begin
            errors++;
            $display("FAIL modes[%0d] got v=%0b d=%h exp v=1 d=%h", i, m_valid, m_data, vexp[i]);
         end
      end
      idle_gap();
   endtask

   task automatic test_s1_swap();
      logic [7:0] vin [3];
      logic [7:0] vexp[3];
      vin  = '{8'h5B, 8'hC1, 8'h7A};
      vexp = '{8'h5B, 8'hC1, 8'h5A};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         s1_valid = 1'b1; s1_data = vin[i]; s1_mode = 2'b11;
         #1;
         checks++; if ({s0_ready, s1_ready} !== 2'b01) begin errors++; $display("FAIL s1_ready[%0d] got=%b exp=01", i, {s0_ready, s1_ready}); end
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b1 || m_data !== vexp[i] || m_id !== 1'b1) begin
            errors++;
            $display("FAIL s1_swap[%0d] got v=%0b d=%h id=%0b exp v=1 d=%h id=1", i, m_valid, m_data, m_id, vexp[i]);
         end
      end
      idle_gap();
   endtask

   // Both valid continuously: 4 from s0, 4 from s1, ... with no gaps.
   task automatic test_back_to_back();
      logic exp_id[12];
      exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      @(negedge clk);
      s0_valid = 1'b1; s0_data = 8'h10; s0_mode = 2'b00;
      s1_valid = 1'b1; s1_data = 8'h20; s1_mode = 2'b00;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b1 || m_id !== exp_id[i] || m_data !== (exp_id[i] ? 8'h20 : 8'h10)) begin
            errors++;
            $display("FAIL burst[%0d] got v=%0b id=%0b d=%h exp v=1 id=%0b", i, m_valid, m_id, m_data, exp_id[i]);
         end
      end
      idle_gap();
   endtask

   // Stall for 3 cycles while 0x41 is held; next byte must follow exactly once.
   task automatic test_backpressure();
      @(negedge clk);
      s0_valid = 1'b1; s0_data = 8'h41; s0_mode = 2'b00; m_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (m_data !== 8'h41 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_first got v=%0b d=%h exp v=1 d=41", m_valid, m_data); end
      @(negedge clk);
      m_ready = 1'b0; s0_data = 8'h42; s1_valid = 1'b1; s1_data = 8'h43; s1_mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {s0_ready, s1_ready}); end
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'h41 || m_id !== 1'b0 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%0b d=%h id=%0b st=%0d exp v=1 d=41 id=0 st=1", i, m_valid, m_data, m_id, dbg_state);
         end
         @(negedge clk);
      end
      m_ready = 1'b1; s1_valid = 1'b0;
      #1;
      checks++; if ({s0_ready, s1_ready} !== 2'b10) begin errors++; $display("FAIL bp_resume_ready got=%b exp=10", {s0_ready, s1_ready}); end
      @(posedge clk); #1;
      checks++; if (m_data !== 8'h42 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_next got v=%0b d=%h exp v=1 d=42", m_valid, m_data); end
      @(negedge clk);
      s0_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got v=%0b exp 0", m_valid); end
      idle_gap();
   endtask

   // s0 sends 2 then drops; s1 takes over at once and then gets a full burst.
   task automatic test_switch_on_drop();
      logic v0[8];
      logic v1[8];
      logic exp_id[8];
      v0     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      v1     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_id = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      s0_data = 8'h30; s0_mode = 2'b00;
      s1_data = 8'h31; s1_mode = 2'b00;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s0_valid = v0[i]; s1_valid = v1[i];
         #1;
         checks++;
         if ({s0_ready, s1_ready} !== (exp_id[i] ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL drop_ready[%0d] got=%b exp_id=%0b", i, {s0_ready, s1_ready}, exp_id[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b1 || m_id !== exp_id[i]) begin
            errors++;
            $display("FAIL drop_id[%0d] got v=%0b id=%0b exp v=1 id=%0b", i, m_valid, m_id, exp_id[i]);
         end
         if (i == 2) begin
            checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL drop_state got=%0d exp=2", dbg_state); end
         end
      end
      idle_gap();
   endtask

   // Reset while a byte is held: output clears at once; s0 then wins a tie.
   task automatic test_reset_mid();
      @(negedge clk);
      s0_valid = 1'b1; s0_data = 8'h55; s0_mode = 2'b00; m_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin errors++; $display("FAIL rmid_pre got v=%0b d=%h exp v=1 d=55", m_valid, m_data); end
      @(negedge clk);
      m_ready = 1'b0; s1_valid = 1'b1; s1_data = 8'h66;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rmid_async got v=%0b d=%h exp v=0 d=00", m_valid, m_data); end
      checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL rmid_ready got=%b exp=00", {s0_ready, s1_ready}); end
      @(negedge clk);
      rst = 1'b0; m_ready = 1'b1;
      #1;
      checks++; if ({s0_ready, s1_ready} !== 2'b10) begin errors++; $display("FAIL rmid_first_grant got=%b exp=10", {s0_ready, s1_ready}); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1 || m_id !== 1'b0 || m_data !== 8'h55) begin errors++; $display("FAIL rmid_first_out got v=%0b id=%0b d=%h exp v=1 id=0 d=55", m_valid, m_id, m_data); end
      idle_gap();
   endtask

   initial begin
      rst = 1'b1;
      s0_valid = 1'b0; s0_data = 8'h00; s0_mode = 2'b00;
      s1_valid = 1'b0; s1_data = 8'h00; s1_mode = 2'b00;
      m_ready = 1'b1;
      test_reset();
      test_single();
      test_modes();
      test_s1_swap();
      test_back_to_back();
      test_backpressure();
      test_switch_on_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
